// File: rtl/shreg_pkg.sv
// Shared mode encodings and helpers for the universal shift register.
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    // True for the four modes that advance the frame counter.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR) ||
               (mode == MODE_ROL) || (mode == MODE_ROR);
    endfunction

endpackage

// File: rtl/shreg_frame_counter.sv
// Counts shift/rotate operations and pulses frame_done when WIDTH of them complete.
module shreg_frame_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;

    // Clear wins over increment; a wrap restarts the count and flags the frame.
    always_comb begin
        cnt_next  = cnt_reg;
        done_next = 1'b0;
        if (clr) begin
            cnt_next = '0;
        end else if (inc) begin
            if (cnt_reg == LAST_CNT) begin
                cnt_next  = '0;
                done_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            done_reg <= done_next;
        end
    end

    assign shift_cnt  = cnt_reg;
    assign frame_done = done_reg;

endmodule

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register (hold/shift/rotate/load/clear) with frame counter.
// Optional registered parity output enabled by defining SHREG_PARITY_EN.
module param_universal_shift_register
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             frame_done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    logic [WIDTH-1:0] q_reg, q_next;
    logic             cnt_inc, cnt_clr;

    // Reserved and unknown codes fall to default, so q only ever holds.
    always_comb begin
        q_next = q_reg;
        case (mode)
            MODE_SHL:  q_next = {q_reg[WIDTH-2:0], ser_in};
            MODE_SHR:  q_next = {ser_in, q_reg[WIDTH-1:1]};
            MODE_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            MODE_ROR:  q_next = {q_reg[0], q_reg[WIDTH-1:1]};
            MODE_LOAD: q_next = par_in;
            MODE_CLR:  q_next = '0;
            default:   q_next = q_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign cnt_inc = is_shift_mode(mode);
    assign cnt_clr = (mode == MODE_LOAD) || (mode == MODE_CLR);

    shreg_frame_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (cnt_inc),
        .clr        (cnt_clr),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

`ifdef SHREG_PARITY_EN
    logic parity_reg;

    // Computed from q_next so it tracks q in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= ^q_next;
        end
    end

    assign parity = parity_reg;
`endif

    assign q           = q_reg;
    assign ser_out_msb = q_reg[WIDTH-1];
    assign ser_out_lsb = q_reg[0];

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed self-checking bench for param_universal_shift_register at WIDTH=8.
module tb_param_universal_shift_register;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       mode;
    logic             ser_in;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] q;
    logic             ser_out_msb;
    logic             ser_out_lsb;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;
`ifdef SHREG_PARITY_EN
    logic             parity;
`endif

    int tests  = 0;
    int failed = 0;

    param_universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .ser_in      (ser_in),
        .par_in      (par_in),
        .q           (q),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .shift_cnt   (shift_cnt),
        .frame_done  (frame_done)
`ifdef SHREG_PARITY_EN
        ,
        .parity      (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic [2:0] m, input logic s, input logic [7:0] p);
        mode   = m;
        ser_in = s;
        par_in = p;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bits_des;
    logic [7:0] bits_ser;

    initial begin
        rst = 1'b1; mode = 3'b001; ser_in = 1'b1; par_in = 8'h00;
        bits_des = 8'b1011_0010;
        bits_ser = 8'hA5;

        // Reset held for two edges while SHL is requested
        step(3'b001, 1'b1, 8'h00);
        step(3'b001, 1'b1, 8'h00);
        chk("rst_q", 64'(q), 64'h00);
        chk("rst_cnt", 64'(shift_cnt), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
`ifdef SHREG_PARITY_EN
        chk("rst_parity", 64'(parity), 64'd0);
`endif
        rst = 1'b0;

        // Deserialize 1,0,1,1,0,0,1,0
        for (int i = 0; i < 8; i++) begin
            step(3'b001, bits_des[7-i], 8'h00);
            if (i == 6) begin
                chk("des_cnt7", 64'(shift_cnt), 64'd7);
                chk("des_done7", 64'(frame_done), 64'd0);
            end
        end
        chk("des_q", 64'(q), 64'hB2);
        chk("des_done", 64'(frame_done), 64'd1);
        chk("des_cnt", 64'(shift_cnt), 64'd0);
        step(3'b000, 1'b0, 8'h00);
        chk("des_done_off", 64'(frame_done), 64'd0);

        // Serializer: MSB-first out of A5
        step(3'b101, 1'b0, 8'hA5);
        chk("ser_load_q", 64'(q), 64'hA5);
        for (int i = 0; i < 8; i++) begin
            chk("ser_msb", 64'(ser_out_msb), 64'(bits_ser[7-i]));
            step(3'b001, 1'b0, 8'h00);
        end
        chk("ser_q", 64'(q), 64'h00);
        chk("ser_done", 64'(frame_done), 64'd1);

        // Rotate
        step(3'b101, 1'b0, 8'h81);
        chk("rot_lsb", 64'(ser_out_lsb), 64'd1);
        step(3'b011, 1'b0, 8'h00);
        chk("rol_q", 64'(q), 64'h03);
        step(3'b100, 1'b0, 8'h00);
        chk("ror1_q", 64'(q), 64'h81);
        step(3'b100, 1'b0, 8'h00);
        chk("ror2_q", 64'(q), 64'hC0);
        chk("rot_cnt", 64'(shift_cnt), 64'd3);
        step(3'b101, 1'b0, 8'h01);
        chk("load_cnt", 64'(shift_cnt), 64'd0);
        step(3'b010, 1'b1, 8'h00);
        chk("shr_q", 64'(q), 64'h80);

        // Hold and reserved codes, then clear
        step(3'b101, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) step(3'b000, 1'b1, 8'hFF);
        chk("hold_q", 64'(q), 64'h5A);
        for (int i = 0; i < 3; i++) step(3'b111, 1'b1, 8'hFF);
        chk("rsv_q", 64'(q), 64'h5A);
        chk("rsv_cnt", 64'(shift_cnt), 64'd0);
        chk("rsv_done", 64'(frame_done), 64'd0);
        step(3'b110, 1'b1, 8'hFF);
        chk("clr_q", 64'(q), 64'h00);

        // Mid-frame reset discards progress
        for (int i = 0; i < 5; i++) step(3'b001, 1'b1, 8'h00);
        chk("mid_cnt5", 64'(shift_cnt), 64'd5);
        rst = 1'b1;
        step(3'b001, 1'b1, 8'h00);
        rst = 1'b0;
        chk("mid_rst_cnt", 64'(shift_cnt), 64'd0);
        chk("mid_rst_done", 64'(frame_done), 64'd0);
        for (int i = 0; i < 7; i++) step(3'b001, 1'b1, 8'h00);
        chk("mid_done7", 64'(frame_done), 64'd0);
        chk("mid_cnt7", 64'(shift_cnt), 64'd7);
        step(3'b001, 1'b1, 8'h00);
        chk("mid_done8", 64'(frame_done), 64'd1);

`ifdef SHREG_PARITY_EN
        step(3'b101, 1'b0, 8'h07);
        chk("par_load", 64'(parity), 64'd1);
        step(3'b001, 1'b1, 8'h00);
        chk("par_shl_q", 64'(q), 64'h0F);
        chk("par_shl", 64'(parity), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
